icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Sequences instruction-cache refills for the fetch stage.
- On a tag miss it stalls fetch (`pc_write` gating), captures the missing PC and requests the line from memory.
- It streams the returned 64-bit beats into the icache over the fill port, then writes the tag.
- It sits between fetch/icache/tags and the memory-side bus, and keeps a saturating refill count for performance monitoring.

Parameters:
- LINE_BEATS, 4, 64-bit beats per cache line; power of two, 1..32.
- OFF_W, 2, log2(LINE_BEATS); must be consistent with LINE_BEATS.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset.
- miss  in  1  tag miss for the current fetch PC.
- pc  in  32  current fetch PC.
- stall  out  1  fetch stall; combinational = miss | (state != IDLE).
- busy  out  1  registered; high when state != IDLE.
- mem_req  out  1  memory read request.
- mem_addr  out  32  line-aligned read address.
- mem_gnt  in  1  request accepted.
- mem_valid  in  1  read beat valid.
- mem_data  in  64  read beat data.
- fill  out  1  icache write strobe.
- fill_idx  out  5  icache doubleword index.
- stream  out  64  icache write data.
- tag_write  out  1  tag store write strobe.
- tag_idx  out  5  doubleword index of the line base (pc[7:3] with low OFF_W bits cleared).
- tag_value  out  24  tag, pc[31:8].
- refills  out  16  completed-refill counter, saturating.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; beat counter=0; refills=0; captured PC=0. mem_req, fill, tag_write, busy all 0; fill_idx=0, stream=0. Reset mid-refill aborts immediately, and any later mem_valid is ignored.
- States: IDLE, REQ, FILL, TAG.
- IDLE: if miss=1, capture pc into miss_pc and go to REQ. stall is already 1 combinationally in this cycle.
- REQ:
  - mem_req=1; mem_addr = {miss_pc[31:3+OFF_W], (3+OFF_W)'b0}, held stable until mem_gnt.
  - mem_gnt=1 → FILL, beat=0, mem_req drops next cycle.
  - mem_valid is never accepted in REQ (earliest beat is the cycle after gnt).
- FILL:
  - Each cycle with mem_valid=1: next cycle fill=1, stream=mem_data, fill_idx = {miss_pc[7:3+OFF_W], beat}; then beat increments.
  - Gaps (mem_valid=0) produce fill=0 and no other change.
  - When the beat with index LINE_BEATS-1 is accepted, go to TAG.
- TAG (one cycle):
  - The last fill write occurs this cycle.
  - tag_write=1, tag_idx = {miss_pc[7:3+OFF_W], OFF_W'b0}, tag_value = miss_pc[31:8].
  - refills increments unless it is 0xFFFF. Next state IDLE.
- fill, tag_write and busy are registered outputs; in all other cycles fill=0 and tag_write=0.
- Latency: each beat is written 1 cycle after mem_valid. Minimum miss-to-IDLE is 1 (IDLE) + 1 (REQ with gnt) + LINE_BEATS + 1 (TAG) cycles.
- Refill is non-abortable except by reset. PC changes (e.g. a branch) during REQ/FILL/TAG are ignored; only miss_pc is used.
- miss sampled in TAG is ignored. In the cycle after TAG the state is IDLE and miss is re-evaluated against the updated tag.
- mem_valid in IDLE, REQ or TAG is ignored.
- Beat index wraps naturally at LINE_BEATS; there is no critical-word-first ordering.

Test Plan:
- Basic refill: pc=0x0000_1234, miss=1, gnt 2 cycles after req, 4 back-to-back beats D0..D3 → mem_addr=0x0000_1220; fill_idx 4,5,6,7 with D0..D3; then tag_write=1, tag_idx=0x04, tag_value=0x000012; refills=1; stall low the cycle after TAG once miss=0.
- Gapped beats: as above but mem_valid pattern 1,0,0,1,1,0,1 → exactly 4 fill pulses, each 1 cycle after its valid; no fill during gaps; TAG follows the 4th fill.
- PC change mid-refill: switch pc to 0x0000_4000 during FILL → mem_addr and fill_idx/tag_value still derived from 0x1234.
- Reset mid-FILL after 2 beats: rst_n=0 one cycle, then 2 stray mem_valid → all outputs 0, state IDLE, no fill, refills=0.
- Stray/early valid: mem_valid=1 in IDLE and in the same cycle as mem_gnt → ignored; line still needs 4 beats after gnt.
- Saturation: force 65536 refills (or preload via repeated misses in a fast bench) → refills stays 0xFFFF.

Source files
------------

// File: rtl/icache_refill_if.sv
// Fetch/icache/tag-store and memory-side signals of the icache refill controller.
// master: the refill controller; slave: the surrounding fetch/memory environment.
interface icache_refill_if;
    logic        miss;
    logic [31:0] pc;
    logic        stall;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_valid;
    logic [63:0] mem_data;
    logic        fill;
    logic [4:0]  fill_idx;
    logic [63:0] stream;
    logic        tag_write;
    logic [4:0]  tag_idx;
    logic [23:0] tag_value;
    logic [15:0] refills;

    modport master (
        input  miss, pc, mem_gnt, mem_valid, mem_data,
        output stall, busy, mem_req, mem_addr, fill, fill_idx, stream,
               tag_write, tag_idx, tag_value, refills
    );

    modport slave (
        output miss, pc, mem_gnt, mem_valid, mem_data,
        input  stall, busy, mem_req, mem_addr, fill, fill_idx, stream,
               tag_write, tag_idx, tag_value, refills
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill sequencer: stalls fetch on a tag miss, fetches the line
// beat by beat from memory, streams it into the icache and then writes the tag.
module icache_refill_ctrl #(
    parameter int LINE_BEATS = 4,
    parameter int OFF_W      = 2
) (
    input logic             clk,
    input logic             rst_n,
    icache_refill_if.master bus
);
    localparam int BW = (OFF_W > 0) ? OFF_W : 1;

    if (LINE_BEATS != (1 << OFF_W) || LINE_BEATS < 1 || LINE_BEATS > 32) begin : g_bad_params
        $error("icache_refill_ctrl: LINE_BEATS must be 2**OFF_W within 1..32");
    end

    typedef enum logic [1:0] {IDLE, REQ, FILL, TAG} state_t;

    state_t      state;
    logic [31:0] miss_pc;
    logic [BW-1:0] beat;
    logic [15:0] refill_cnt;
    logic [4:0]  base_idx;
    logic        unused_pc_lsb;

    // Masking rather than slicing keeps the 1-beat and 32-beat line sizes legal.
    assign base_idx      = miss_pc[7:3] & ~5'(LINE_BEATS - 1);
    assign bus.mem_addr  = {miss_pc[31:3], 3'b000} & ~(32'(LINE_BEATS - 1) << 3);
    assign bus.mem_req   = (state == REQ);
    assign bus.stall     = bus.miss | (state != IDLE);
    assign bus.tag_idx   = base_idx;
    assign bus.tag_value = miss_pc[31:8];
    assign bus.refills   = refill_cnt;
    assign unused_pc_lsb = ^miss_pc[2:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            miss_pc       <= '0;
            beat          <= '0;
            refill_cnt    <= '0;
            bus.busy      <= 1'b0;
            bus.fill      <= 1'b0;
            bus.fill_idx  <= '0;
            bus.stream    <= '0;
            bus.tag_write <= 1'b0;
        end else begin
            bus.fill      <= 1'b0;
            bus.tag_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.miss) begin
                        miss_pc  <= bus.pc;
                        state    <= REQ;
                        bus.busy <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        state <= FILL;
                        beat  <= '0;
                    end
                end
                FILL: begin
                    if (bus.mem_valid) begin
                        bus.fill     <= 1'b1;
                        bus.stream   <= bus.mem_data;
                        bus.fill_idx <= base_idx | 5'(beat);
                        beat         <= beat + 1'b1;
                        // tag_write lands together with the last beat's fill write
                        if (beat == BW'(LINE_BEATS - 1)) begin
                            state         <= TAG;
                            bus.tag_write <= 1'b1;
                        end
                    end
                end
                TAG: begin
                    if (refill_cnt != '1) begin
                        refill_cnt <= refill_cnt + 16'd1;
                    end
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a transaction-level model checked every cycle,
// plus literal expectations for addresses, indices, tags and the refill counter.
module tb_icache_refill_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_refill_if bus();

    icache_refill_ctrl #(.LINE_BEATS(4), .OFF_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: one outstanding refill, tracked as "active / granted / beats received".
    bit          m_active, m_granted, m_tag, e_fill;
    int          m_beats;
    int          m_refills;
    logic [31:0] m_pc;
    logic [63:0] e_stream;
    int          e_idx;

    logic [4:0]  fill_log[$];
    logic [23:0] tag_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int line_idx(input logic [31:0] a);
        return int'((a / 8) % 32) / 4 * 4;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_active = 0; m_granted = 0; m_tag = 0; e_fill = 0;
            m_beats = 0; m_refills = 0; m_pc = '0;
        end else begin
            e_fill = 0;
            if (m_tag) begin
                m_tag = 0;
                m_active = 0;
                if (m_refills != 65535) m_refills++;
            end else if (!m_active) begin
                if (bus.miss) begin
                    m_active = 1; m_granted = 0; m_beats = 0; m_pc = bus.pc;
                end
            end else if (!m_granted) begin
                if (bus.mem_gnt) m_granted = 1;
            end else if (bus.mem_valid) begin
                e_fill = 1;
                e_stream = bus.mem_data;
                e_idx = line_idx(m_pc) + m_beats;
                m_beats++;
                if (m_beats == 4) m_tag = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("stall", bus.stall, bus.miss | m_active);
        chk("busy", bus.busy, m_active);
        chk("mem_req", bus.mem_req, m_active && !m_granted);
        if (m_active && !m_granted) chk("mem_addr", bus.mem_addr, m_pc - (m_pc % 32));
        chk("fill", bus.fill, e_fill);
        if (e_fill) begin
            chk("fill_idx", bus.fill_idx, e_idx);
            chk("stream", bus.stream, e_stream);
        end
        chk("tag_write", bus.tag_write, m_tag);
        if (m_tag) begin
            chk("tag_idx", bus.tag_idx, line_idx(m_pc));
            chk("tag_value", bus.tag_value, m_pc / 256);
        end
        chk("refills", bus.refills, m_refills);
        if (bus.fill === 1'b1) fill_log.push_back(bus.fill_idx);
        if (bus.tag_write === 1'b1) tag_log.push_back(bus.tag_value);
    endtask

    // One clock: model sees the inputs sampled at the edge, outputs compared 2 ns later,
    // next inputs applied on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        #2;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_miss(input logic [31:0] a);
        bus.pc = a;
        bus.miss = 1'b1;
        cycle();
        bus.miss = 1'b0;
    endtask

    task automatic grant(input int wait_cycles, input bit with_valid);
        repeat (wait_cycles) cycle();
        bus.mem_gnt = 1'b1;
        bus.mem_valid = with_valid;
        bus.mem_data = 64'hBAD0_BAD0_BAD0_BAD0;
        cycle();
        bus.mem_gnt = 1'b0;
        bus.mem_valid = 1'b0;
    endtask

    task automatic beats(input logic [15:0] pat, input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            bus.mem_valid = pat[i];
            bus.mem_data = base + 64'(i);
            cycle();
        end
        bus.mem_valid = 1'b0;
    endtask

    task automatic refill_full(input logic [31:0] a);
        do_miss(a);
        grant(0, 0);
        beats(16'hF, 4, 64'h5500);
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.miss = 1'b0; bus.pc = '0; bus.mem_gnt = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_data = '0;
        cycle();
        cycle();
        chk("rst_busy", bus.busy, 0);
        chk("rst_fill", bus.fill, 0);
        chk("rst_fill_idx", bus.fill_idx, 0);
        chk("rst_stream", bus.stream, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_refills", bus.refills, 0);
        rst_n = 1'b1;
        cycle();

        // Basic refill
        fill_log.delete(); tag_log.delete();
        do_miss(32'h0000_1234);
        chk("basic_mem_addr", bus.mem_addr, 32'h0000_1220);
        grant(2, 0);
        beats(16'hF, 4, 64'hD0);
        chk("basic_tag_write", bus.tag_write, 1);
        chk("basic_tag_idx", bus.tag_idx, 5'h04);
        chk("basic_tag_value", bus.tag_value, 24'h000012);
        chk("basic_last_stream", bus.stream, 64'hD3);
        cycle();
        chk("basic_refills", bus.refills, 1);
        chk("basic_stall_low", bus.stall, 0);
        chk("basic_fill_count", fill_log.size(), 4);
        for (int i = 0; i < fill_log.size(); i++) chk("basic_fill_idx_seq", fill_log[i], 4 + i);

        // Gapped beats: valid 1,0,0,1,1,0,1
        fill_log.delete();
        do_miss(32'h0000_1234);
        grant(0, 0);
        beats(16'b1011001, 7, 64'hE0);
        chk("gap_tag_write", bus.tag_write, 1);
        cycle();
        chk("gap_fill_count", fill_log.size(), 4);
        chk("gap_refills", bus.refills, 2);

        // PC change during FILL, miss asserted in TAG, then a refill of the new PC
        tag_log.delete();
        do_miss(32'h0000_1234);
        grant(1, 0);
        beats(16'h3, 2, 64'hA0);
        bus.pc = 32'h0000_4000;
        beats(16'h3, 2, 64'hA2);
        bus.miss = 1'b1;
        cycle();
        chk("pcchg_idle_busy", bus.busy, 0);
        cycle();
        bus.miss = 1'b0;
        chk("pcchg_new_addr", bus.mem_addr, 32'h0000_4000);
        grant(0, 0);
        beats(16'hF, 4, 64'hB0);
        cycle();
        chk("pcchg_tag_count", tag_log.size(), 2);
        if (tag_log.size() == 2) begin
            chk("pcchg_tag0", tag_log[0], 24'h000012);
            chk("pcchg_tag1", tag_log[1], 24'h000040);
        end
        chk("pcchg_refills", bus.refills, 4);

        // Reset after two beats, then stray valids
        fill_log.delete();
        do_miss(32'h0000_1234);
        grant(0, 0);
        beats(16'h3, 2, 64'hC0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        beats(16'h3, 2, 64'hC2);
        cycle();
        chk("rst_mid_fill_count", fill_log.size(), 2);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_refills", bus.refills, 0);
        chk("rst_mid_tag_value", bus.tag_value, 0);

        // Stray valid in IDLE and with the grant; line still needs 4 beats
        fill_log.delete();
        bus.mem_valid = 1'b1;
        cycle();
        bus.mem_valid = 1'b0;
        do_miss(32'h0000_12F8);
        grant(1, 1);
        beats(16'h7, 3, 64'hF0);
        chk("stray_not_done", bus.tag_write, 0);
        chk("stray_busy", bus.busy, 1);
        beats(16'h1, 1, 64'hF3);
        chk("stray_tag_idx", bus.tag_idx, 5'h1C);
        cycle();
        chk("stray_fill_count", fill_log.size(), 4);
        chk("stray_refills", bus.refills, 1);

        // Saturation: preload the counter just below the top
        force dut.refill_cnt = 16'hFFFE;
        m_refills = 65534;
        cycle();
        release dut.refill_cnt;
        cycle();
        chk("sat_preload", bus.refills, 16'hFFFE);
        refill_full(32'h0001_0000);
        chk("sat_reach", bus.refills, 16'hFFFF);
        refill_full(32'h0002_0040);
        chk("sat_hold", bus.refills, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
